// File: rtl/fractal_sync_mp_req_ctrl.sv
// Multi-port barrier request front-end for the fractal sync CAM.
// Pairs same-cycle requests, resolves the rest against the CAM and tracks occupancy.
module fractal_sync_mp_req_ctrl #(
    parameter int SIG_WIDTH = 1,
    parameter int N_PORTS   = 2,
    parameter int N_LINES   = 1,
    localparam int OW       = $clog2(N_LINES + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_PORTS-1:0]                  req_valid_i,
    output logic [N_PORTS-1:0]                  req_ready_o,
    input  logic [N_PORTS-1:0][SIG_WIDTH-1:0]   req_sig_i,
    output logic [N_PORTS-1:0]                  rsp_valid_o,
    input  logic [N_PORTS-1:0]                  rsp_ready_i,
    output logic [N_PORTS-1:0]                  rsp_match_o,
    output logic [N_PORTS-1:0][SIG_WIDTH-1:0]   cam_sig_o,
    output logic [N_PORTS-1:0]                  cam_sig_write_o,
    input  logic [N_PORTS-1:0]                  cam_present_i,
    output logic [OW-1:0]                       occupancy_o
);

    localparam int CW = $clog2(N_LINES + N_PORTS + 1);
    localparam logic [CW-1:0] LINES = CW'(N_LINES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    if (N_PORTS < 2) begin : g_bad_ports
        $fatal(1, "N_PORTS must be at least 2");
    end
    if (N_LINES < N_PORTS / 2) begin : g_bad_lines
        $fatal(1, "N_LINES too small for N_PORTS");
    end

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t                              state_q [N_PORTS];
    state_t                              state_d [N_PORTS];
    logic [N_PORTS-1:0][SIG_WIDTH-1:0]   sig_q;
    logic [N_PORTS-1:0]                  sig_load;
    logic [N_PORTS-1:0]                  match_q;
    logic [N_PORTS-1:0]                  match_d;
    logic [N_PORTS-1:0]                  peer;
    logic [N_PORTS-1:0]                  hit;
    logic [N_PORTS-1:0]                  grant;
    logic [OW-1:0]                       occ_q;
    logic [CW-1:0]                       occ_ext;
    logic [CW-1:0]                       n_grant;
    logic [CW-1:0]                       n_hit;
    logic [CW-1:0]                       occ_sum;

    assign occ_ext = CW'(occ_q);

    // Peers pair greedily by index; capacity uses occupancy at cycle start only.
    always_comb begin
        peer    = '0;
        hit     = '0;
        grant   = '0;
        n_grant = '0;
        n_hit   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            for (int j = i + 1; j < N_PORTS; j++) begin
                if (!peer[i] && !peer[j] &&
                    state_q[i] == CHECK && state_q[j] == CHECK &&
                    sig_q[i] == sig_q[j]) begin
                    peer[i] = 1'b1;
                    peer[j] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N_PORTS; i++) begin
            if (state_q[i] == CHECK && !peer[i]) begin
                if (cam_present_i[i]) begin
                    hit[i] = 1'b1;
                    n_hit  = n_hit + ONE;
                end else if (occ_ext + n_grant < LINES) begin
                    grant[i] = 1'b1;
                    n_grant  = n_grant + ONE;
                end
            end
        end
    end

    always_comb begin
        sig_load = '0;
        match_d  = match_q;
        for (int i = 0; i < N_PORTS; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                IDLE: begin
                    if (req_valid_i[i]) begin
                        state_d[i]  = CHECK;
                        sig_load[i] = 1'b1;
                    end
                end
                CHECK: begin
                    if (peer[i] || hit[i] || grant[i]) begin
                        state_d[i] = RESP;
                        match_d[i] = peer[i] || hit[i];
                    end
                end
                RESP: begin
                    if (rsp_ready_i[i]) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            req_ready_o[i] = (state_q[i] == IDLE);
            rsp_valid_o[i] = (state_q[i] == RESP);
            cam_sig_o[i]   = (state_q[i] == CHECK) ? sig_q[i] : '0;
        end
    end

    assign cam_sig_write_o = grant;
    assign rsp_match_o     = match_q;
    assign occupancy_o     = occ_q;
    assign occ_sum         = occ_ext + n_grant - n_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_PORTS; i++) begin
                state_q[i] <= IDLE;
            end
            sig_q   <= '0;
            match_q <= '0;
            occ_q   <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                state_q[i] <= state_d[i];
                if (sig_load[i]) sig_q[i] <= req_sig_i[i];
            end
            match_q <= match_d;
            occ_q   <= OW'(occ_sum);
        end
    end

    // A CAM hit consumes a waiting entry, so hits can never outnumber entries.
    a_no_underflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni) n_hit <= occ_ext
    );

endmodule

// File: tb/tb_fractal_sync_mp_req_ctrl.sv
// Bench for fractal_sync_mp_req_ctrl: reference model with a CAM model
// plus directed scenarios with literal expectations.
module tb_fractal_sync_mp_req_ctrl;

    localparam int SW = 4;
    localparam int NP = 3;
    localparam int NL = 1;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic [NP-1:0]         req_valid_i = '0;
    logic [NP-1:0]         req_ready_o;
    logic [NP-1:0][SW-1:0] req_sig_i = '0;
    logic [NP-1:0]         rsp_valid_o;
    logic [NP-1:0]         rsp_ready_i = '1;
    logic [NP-1:0]         rsp_match_o;
    logic [NP-1:0][SW-1:0] cam_sig_o;
    logic [NP-1:0]         cam_sig_write_o;
    logic [NP-1:0]         cam_present_i;
    logic [0:0]            occupancy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    fractal_sync_mp_req_ctrl #(
        .SIG_WIDTH(SW),
        .N_PORTS  (NP),
        .N_LINES  (NL)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_sig_i      (req_sig_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_match_o    (rsp_match_o),
        .cam_sig_o      (cam_sig_o),
        .cam_sig_write_o(cam_sig_write_o),
        .cam_present_i  (cam_present_i),
        .occupancy_o    (occupancy_o)
    );

    // Reference: ph 0 = waiting for request, 1 = looking up, 2 = answering.
    int          ph [NP];
    logic [SW-1:0] hs [NP];
    bit          em [NP];
    logic [SW-1:0] cs [4];
    int          cn;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            cam_present_i[i] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (k < cn && cs[k] == cam_sig_o[i]) cam_present_i[i] = 1'b1;
            end
        end
    end

    // Outcome per port: 0 none/stall, 1 peer match, 2 CAM match, 3 store.
    function automatic logic [NP-1:0][1:0] resolve();
        logic [NP-1:0][1:0] k;
        bit used [NP];
        int g;
        bit found;
        k = '0;
        g = 0;
        for (int i = 0; i < NP; i++) used[i] = 0;
        for (int i = 0; i < NP; i++) begin
            for (int j = i + 1; j < NP; j++) begin
                if (ph[i] == 1 && ph[j] == 1 && !used[i] && !used[j] && hs[i] == hs[j]) begin
                    used[i] = 1;
                    used[j] = 1;
                    k[i] = 2'd1;
                    k[j] = 2'd1;
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (ph[i] == 1 && !used[i]) begin
                found = 0;
                for (int m = 0; m < cn; m++) if (cs[m] == hs[i]) found = 1;
                if (found) k[i] = 2'd2;
                else if (cn + g + 1 <= NL) begin
                    k[i] = 2'd3;
                    g++;
                end
            end
        end
        return k;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NP; i++) begin
                ph[i] <= 0;
                em[i] <= 0;
                hs[i] <= '0;
            end
            cn <= 0;
        end else begin
            automatic logic [NP-1:0][1:0] k = resolve();
            automatic logic [SW-1:0] ncs [4] = cs;
            automatic int ncn = cn;
            automatic int at;
            for (int i = 0; i < NP; i++) begin
                case (ph[i])
                    0: if (req_valid_i[i]) begin
                        ph[i] <= 1;
                        hs[i] <= req_sig_i[i];
                    end
                    1: if (k[i] != 2'd0) begin
                        ph[i] <= 2;
                        em[i] <= (k[i] != 2'd3);
                        if (k[i] == 2'd3) begin
                            ncs[ncn] = hs[i];
                            ncn++;
                        end
                        if (k[i] == 2'd2) begin
                            at = -1;
                            for (int m = 0; m < ncn; m++) if (at < 0 && ncs[m] == hs[i]) at = m;
                            for (int m = 0; m < 3; m++) if (at >= 0 && m >= at) ncs[m] = ncs[m+1];
                            ncn--;
                        end
                    end
                    default: if (rsp_ready_i[i]) ph[i] <= 0;
                endcase
            end
            cs <= ncs;
            cn <= ncn;
        end
    end

    task automatic chk(string nm, int p, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s port=%0d got=%0h want=%0h t=%0t", nm, p, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            automatic logic [NP-1:0][1:0] k = resolve();
            for (int i = 0; i < NP; i++) begin
                chk("req_ready", i, 32'(req_ready_o[i]), 32'(ph[i] == 0));
                chk("rsp_valid", i, 32'(rsp_valid_o[i]), 32'(ph[i] == 2));
                if (ph[i] == 2) chk("rsp_match", i, 32'(rsp_match_o[i]), 32'(em[i]));
                chk("cam_sig", i, 32'(cam_sig_o[i]), (ph[i] == 1) ? 32'(hs[i]) : 32'd0);
                chk("cam_write", i, 32'(cam_sig_write_o[i]), 32'(k[i] == 2'd3));
            end
            chk("occupancy", -1, 32'(occupancy_o), 32'(cn));
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic vs(int p, logic [SW-1:0] s);
        req_valid_i[p] = 1'b1;
        req_sig_i[p]   = s;
    endtask

    task automatic clr();
        req_valid_i = '0;
    endtask

    initial begin
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        chk("lit_reset_ready", -1, 32'(req_ready_o), 32'h7);
        chk("lit_reset_rspv", -1, 32'(rsp_valid_o), 32'h0);
        chk("lit_reset_occ", -1, 32'(occupancy_o), 32'h0);

        // First waiter stores its signature.
        vs(0, 4'h3);
        tick(); clr();
        chk("lit_a_write", -1, 32'(cam_sig_write_o), 32'h1);
        chk("lit_a_camsig", 0, 32'(cam_sig_o[0]), 32'h3);
        tick();
        chk("lit_a_rspv", -1, 32'(rsp_valid_o), 32'h1);
        chk("lit_a_match", 0, 32'(rsp_match_o[0]), 32'h0);
        chk("lit_a_occ", -1, 32'(occupancy_o), 32'h1);
        tick();

        // Partner hits the waiting entry.
        vs(1, 4'h3);
        tick(); clr();
        chk("lit_b_write", -1, 32'(cam_sig_write_o), 32'h0);
        chk("lit_b_present", 1, 32'(cam_present_i[1]), 32'h1);
        tick();
        chk("lit_b_rspv", 1, 32'(rsp_valid_o[1]), 32'h1);
        chk("lit_b_match", 1, 32'(rsp_match_o[1]), 32'h1);
        chk("lit_b_occ", -1, 32'(occupancy_o), 32'h0);
        tick();

        // Same-cycle pair.
        vs(0, 4'h5); vs(1, 4'h5);
        tick(); clr();
        chk("lit_c_write", -1, 32'(cam_sig_write_o), 32'h0);
        tick();
        chk("lit_c_rspv", -1, 32'(rsp_valid_o), 32'h3);
        chk("lit_c_match", -1, 32'(rsp_match_o[1:0]), 32'h3);
        chk("lit_c_occ", -1, 32'(occupancy_o), 32'h0);
        tick();

        // Full CAM: two new signatures stall until hits free the line.
        vs(0, 4'h3);
        tick(); clr();
        tick(); tick();
        vs(0, 4'h7); vs(1, 4'h8);
        tick(); clr();
        chk("lit_d_write0", -1, 32'(cam_sig_write_o), 32'h0);
        tick();
        chk("lit_d_stall_ready", -1, 32'(req_ready_o[1:0]), 32'h0);
        chk("lit_d_stall_rspv", -1, 32'(rsp_valid_o), 32'h0);
        vs(2, 4'h3);
        tick(); clr();
        chk("lit_d_hitcycle", -1, 32'(cam_sig_write_o), 32'h0);
        chk("lit_d_present2", 2, 32'(cam_present_i[2]), 32'h1);
        tick();
        chk("lit_d_grant0", -1, 32'(cam_sig_write_o), 32'h1);
        chk("lit_d_occ0", -1, 32'(occupancy_o), 32'h0);
        tick();
        vs(2, 4'h7);
        tick(); clr();
        chk("lit_d_p1_wait", -1, 32'(cam_sig_write_o), 32'h0);
        tick();
        chk("lit_d_grant1", -1, 32'(cam_sig_write_o), 32'h2);
        tick(); tick();
        vs(2, 4'h8);
        tick(); clr();
        tick(); tick();
        chk("lit_d_drained", -1, 32'(occupancy_o), 32'h0);

        // Response back-pressure.
        rsp_ready_i[0] = 1'b0;
        vs(0, 4'h9);
        tick(); clr();
        tick();
        chk("lit_e_rspv", 0, 32'(rsp_valid_o[0]), 32'h1);
        vs(0, 4'h4);
        repeat (4) begin
            tick();
            chk("lit_e_hold_v", 0, 32'(rsp_valid_o[0]), 32'h1);
            chk("lit_e_hold_m", 0, 32'(rsp_match_o[0]), 32'h0);
            chk("lit_e_blocked", 0, 32'(req_ready_o[0]), 32'h0);
        end
        clr();
        rsp_ready_i[0] = 1'b1;
        tick();
        chk("lit_e_release_v", 0, 32'(rsp_valid_o[0]), 32'h0);
        chk("lit_e_release_r", 0, 32'(req_ready_o[0]), 32'h1);
        vs(1, 4'h9);
        tick(); clr();
        tick(); tick();

        // Odd member of a three-way group goes to the CAM.
        vs(0, 4'hA); vs(1, 4'hA); vs(2, 4'hA);
        tick(); clr();
        chk("lit_f_write", -1, 32'(cam_sig_write_o), 32'h4);
        tick();
        chk("lit_f_rspv", -1, 32'(rsp_valid_o), 32'h7);
        chk("lit_f_match", -1, 32'(rsp_match_o), 32'h3);
        chk("lit_f_occ", -1, 32'(occupancy_o), 32'h1);
        tick();

        // Asynchronous reset while a lookup is pending.
        vs(0, 4'hB);
        tick(); clr();
        rst_ni = 1'b0;
        #1;
        chk("lit_g_ready", -1, 32'(req_ready_o), 32'h7);
        chk("lit_g_rspv", -1, 32'(rsp_valid_o), 32'h0);
        chk("lit_g_occ", -1, 32'(occupancy_o), 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("lit_g_after_ready", -1, 32'(req_ready_o), 32'h7);
        chk("lit_g_after_occ", -1, 32'(occupancy_o), 32'h0);

        // Mixed traffic checked by the reference model only.
        for (int n = 0; n < 80; n++) begin
            req_valid_i = 3'($urandom_range(0, 7));
            for (int p = 0; p < NP; p++) req_sig_i[p] = 4'($urandom_range(0, 3));
            rsp_ready_i = 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7));
            tick();
        end
        clr();
        rsp_ready_i = '1;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
